// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//   Shared definitions for the HD44780 writer:
//     - FSM state enum and wait-selector enum
//     - HD44780 command constants
//     - power-on init ROM (length, entries, per-entry wait selector)
//     - helper that classifies slow (clear/home) commands
//   Build option: define LCD_NIBBLE_MODE_EN to select the 4-bit bus init
//   sequence; leave it undefined for the 8-bit bus.
// ---------------------------------------------------------------------------
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP     = 3'd0,
      ST_INIT_LOAD = 3'd1,
      ST_SETUP     = 3'd2,
      ST_PULSE     = 3'd3,
      ST_HOLD      = 3'd4,
      ST_WAIT      = 3'd5,
      ST_IDLE      = 3'd6
   } lcd_state_t;

   // Which post-write wait applies to a byte.
   typedef enum logic [1:0] {
      WSEL_CMD  = 2'd0,
      WSEL_CLR  = 2'd1,
      WSEL_LONG = 2'd2
   } wait_sel_t;

   localparam logic [7:0] LCD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_HOME      = 8'h02;
   localparam logic [7:0] LCD_FUNC_8B   = 8'h38;
   localparam logic [7:0] LCD_FUNC_4B   = 8'h28;
   localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
   localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
   localparam logic [7:0] LCD_WAKE      = 8'h30;
   localparam logic [7:0] LCD_WAKE_4B   = 8'h20;

   // Wait after the very first wake-up write (4.1 ms at a 100 us tick).
   localparam int INIT_LONG_TICKS = 41;

   localparam int INIT_IDX_W = 3;

   // single = 1: only the high nibble is sent (one SETUP/PULSE/HOLD triple)
   // even in nibble mode; unused on the 8-bit bus.
   typedef struct packed {
      logic [7:0] data;
      logic       single;
      wait_sel_t  wsel;
   } init_entry_t;

`ifdef LCD_NIBBLE_MODE_EN
   localparam bit LCD_NIBBLE_MODE = 1'b1;
   localparam int INIT_LEN        = 8;

   function automatic init_entry_t init_rom(input logic [INIT_IDX_W-1:0] idx);
      init_entry_t e;
      case (idx)
         3'd0:    e = '{data: LCD_WAKE,      single: 1'b1, wsel: WSEL_LONG};
         3'd1:    e = '{data: LCD_WAKE,      single: 1'b1, wsel: WSEL_CMD};
         3'd2:    e = '{data: LCD_WAKE,      single: 1'b1, wsel: WSEL_CMD};
         3'd3:    e = '{data: LCD_WAKE_4B,   single: 1'b1, wsel: WSEL_CMD};
         3'd4:    e = '{data: LCD_FUNC_4B,   single: 1'b0, wsel: WSEL_CMD};
         3'd5:    e = '{data: LCD_DISP_ON,   single: 1'b0, wsel: WSEL_CMD};
         3'd6:    e = '{data: LCD_CLEAR,     single: 1'b0, wsel: WSEL_CLR};
         default: e = '{data: LCD_ENTRY_INC, single: 1'b0, wsel: WSEL_CMD};
      endcase
      return e;
   endfunction
`else
   localparam bit LCD_NIBBLE_MODE = 1'b0;
   localparam int INIT_LEN        = 7;

   function automatic init_entry_t init_rom(input logic [INIT_IDX_W-1:0] idx);
      init_entry_t e;
      case (idx)
         3'd0:    e = '{data: LCD_WAKE,      single: 1'b0, wsel: WSEL_LONG};
         3'd1:    e = '{data: LCD_WAKE,      single: 1'b0, wsel: WSEL_CMD};
         3'd2:    e = '{data: LCD_WAKE,      single: 1'b0, wsel: WSEL_CMD};
         3'd3:    e = '{data: LCD_FUNC_8B,   single: 1'b0, wsel: WSEL_CMD};
         3'd4:    e = '{data: LCD_DISP_ON,   single: 1'b0, wsel: WSEL_CMD};
         3'd5:    e = '{data: LCD_CLEAR,     single: 1'b0, wsel: WSEL_CLR};
         default: e = '{data: LCD_ENTRY_INC, single: 1'b0, wsel: WSEL_CMD};
      endcase
      return e;
   endfunction
`endif

   // Clear display (0x01) and return home (0x02/0x03) need the long wait.
   function automatic wait_sel_t wait_sel_for(input logic rs, input logic [7:0] data);
      if (!rs && (data == LCD_CLEAR || data == LCD_HOME || data == 8'h03))
         return WSEL_CLR;
      return WSEL_CMD;
   endfunction

endpackage

// File: rtl/lcd_tick_timer.sv
// ---------------------------------------------------------------------------
// lcd_tick_timer
//   Down-counter clocked by clkIn and decremented only on tickIn pulses.
//   A wait of N ticks is started by loading N-1; done is high while the
//   count is 0, so the owner advances on the N-th tick after the load.
//   Ports:
//     clkIn    in  system clock
//     rstIn    in  synchronous active-high reset (count <= RST_VAL)
//     tickIn   in  one-cycle timing enable
//     load     in  load load_val this cycle (overrides the decrement)
//     load_val in  WAIT_W-bit value to load
//     done     out count has reached 0
// ---------------------------------------------------------------------------
module lcd_tick_timer #(
   parameter int                WAIT_W  = 8,
   parameter logic [WAIT_W-1:0] RST_VAL = '0
) (
   input  logic              clkIn,
   input  logic              rstIn,
   input  logic              tickIn,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   output logic              done
);

   logic [WAIT_W-1:0] count_q;
   logic [WAIT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (tickIn && (count_q != '0))
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clkIn) begin
      if (rstIn)
         count_q <= RST_VAL;
      else
         count_q <= count_d;
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/lcd_hd44780_writer.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_writer
//   Drives an HD44780 character LCD (write-only). After reset it waits
//   PWRUP_TICKS ticks, plays the init ROM, then accepts command/data bytes
//   on a valid/ready handshake and sequences RS/EN/DATA for each one.
//   All LCD timing is counted in tickIn pulses.
//   Build option: LCD_NIBBLE_MODE_EN selects a 4-bit bus on lcdData[7:4]
//   (each byte sent as two strobes, high nibble first); undefined = 8-bit.
//   Ports:
//     clkIn    in   system clock
//     rstIn    in   synchronous active-high reset
//     tickIn   in   one-cycle timing enable from the clock divider
//     wrValid  in   upstream byte valid
//     wrReady  out  block can accept a byte (high only in IDLE)
//     wrRs     in   0 = command, 1 = data
//     wrData   in   byte to write
//     initDone out  init sequence complete, sticky until reset
//     lcdRs    out  LCD register select
//     lcdRw    out  LCD read/write, always 0
//     lcdEn    out  LCD enable strobe
//     lcdData  out  LCD data bus
// ---------------------------------------------------------------------------
module lcd_hd44780_writer
   import lcd_pkg::*;
#(
   parameter int PWRUP_TICKS = 160,
   parameter int CMD_TICKS   = 1,
   parameter int CLR_TICKS   = 20,
   parameter int WAIT_W      = 8
) (
   input  logic       clkIn,
   input  logic       rstIn,
   input  logic       tickIn,
   input  logic       wrValid,
   output logic       wrReady,
   input  logic       wrRs,
   input  logic [7:0] wrData,
   output logic       initDone,
   output logic       lcdRs,
   output logic       lcdRw,
   output logic       lcdEn,
   output logic [7:0] lcdData
);

   lcd_state_t            state_q, state_d;
   logic [INIT_IDX_W-1:0] idx_q, idx_d;
   logic                  rs_q, rs_d;
   logic [7:0]            data_q, data_d;
   wait_sel_t             wsel_q, wsel_d;
   logic                  single_q, single_d;
   logic                  phase_q, phase_d;
   logic                  init_done_q, init_done_d;
   logic                  wr_ready_q, wr_ready_d;
   logic                  lcd_en_q, lcd_en_d;

   logic                  tmr_load;
   logic [WAIT_W-1:0]     tmr_val;
   logic                  tmr_done;
   logic [WAIT_W-1:0]     wait_val;
   init_entry_t           rom_entry;

   // The power-up wait is preloaded by reset so PWRUP needs no load cycle.
   lcd_tick_timer #(
      .WAIT_W  (WAIT_W),
      .RST_VAL (WAIT_W'(PWRUP_TICKS - 1))
   ) u_timer (
      .clkIn    (clkIn),
      .rstIn    (rstIn),
      .tickIn   (tickIn),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign rom_entry = init_rom(idx_q);

   always_comb begin
      case (wsel_q)
         WSEL_LONG: wait_val = WAIT_W'(INIT_LONG_TICKS - 1);
         WSEL_CLR:  wait_val = WAIT_W'(CLR_TICKS - 1);
         default:   wait_val = WAIT_W'(CMD_TICKS - 1);
      endcase
   end

   // A state "lasts one tick" by loading 0 on entry: done is already true,
   // so the next tickIn edge moves on regardless of where in the tick period
   // the state was entered.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rs_d        = rs_q;
      data_d      = data_q;
      wsel_d      = wsel_q;
      single_d    = single_q;
      phase_d     = phase_q;
      init_done_d = init_done_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      case (state_q)
         ST_PWRUP: begin
            if (tickIn && tmr_done)
               state_d = ST_INIT_LOAD;
         end

         // Not tick-gated: fetches the ROM entry in one clock so the
         // following SETUP counts from the next tick like a host write.
         ST_INIT_LOAD: begin
            rs_d     = 1'b0;
            data_d   = rom_entry.data;
            wsel_d   = rom_entry.wsel;
            single_d = rom_entry.single;
            phase_d  = 1'b0;
            tmr_load = 1'b1;
            state_d  = ST_SETUP;
         end

         ST_IDLE: begin
            if (wrValid && wr_ready_q) begin
               rs_d     = wrRs;
               data_d   = wrData;
               wsel_d   = wait_sel_for(wrRs, wrData);
               single_d = 1'b0;
               phase_d  = 1'b0;
               tmr_load = 1'b1;
               state_d  = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (tickIn && tmr_done) begin
               tmr_load = 1'b1;
               state_d  = ST_PULSE;
            end
         end

         ST_PULSE: begin
            if (tickIn && tmr_done) begin
               tmr_load = 1'b1;
               state_d  = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (tickIn && tmr_done) begin
               tmr_load = 1'b1;
               if (LCD_NIBBLE_MODE && !single_q && !phase_q) begin
                  // High nibble done; send the low nibble without waiting.
                  phase_d = 1'b1;
                  state_d = ST_SETUP;
               end else begin
                  tmr_val = wait_val;
                  state_d = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            if (tickIn && tmr_done) begin
               if (!init_done_q && (idx_q != INIT_IDX_W'(INIT_LEN - 1))) begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_INIT_LOAD;
               end else begin
                  init_done_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end

         default: state_d = ST_PWRUP;
      endcase

      // Registered outputs follow the next state so they change on the
      // same edge as the state they belong to.
      wr_ready_d = (state_d == ST_IDLE);
      lcd_en_d   = (state_d == ST_PULSE);
   end

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state_q     <= ST_PWRUP;
         idx_q       <= '0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         wsel_q      <= WSEL_CMD;
         single_q    <= 1'b0;
         phase_q     <= 1'b0;
         init_done_q <= 1'b0;
         wr_ready_q  <= 1'b0;
         lcd_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         wsel_q      <= wsel_d;
         single_q    <= single_d;
         phase_q     <= phase_d;
         init_done_q <= init_done_d;
         wr_ready_q  <= wr_ready_d;
         lcd_en_q    <= lcd_en_d;
      end
   end

   assign wrReady  = wr_ready_q;
   assign initDone = init_done_q;
   assign lcdRs    = rs_q;
   assign lcdRw    = 1'b0;
   assign lcdEn    = lcd_en_q;
   // In nibble mode the active nibble rides on [7:4]; [3:0] stays 0.
   assign lcdData  = LCD_NIBBLE_MODE ? (phase_q ? {data_q[3:0], 4'h0} : {data_q[7:4], 4'h0})
                                     : data_q;

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_hd44780_writer
//   Driver pushes expected LCD strobes and expected wrReady latencies into
//   queues; an independent monitor pops them as the DUT strobes lcdEn or
//   raises wrReady. Supports the 8-bit build and LCD_NIBBLE_MODE_EN.
// ---------------------------------------------------------------------------
module tb_lcd_hd44780_writer;

   localparam int PWRUP_TICKS = 4;
   localparam int CMD_TICKS   = 1;
   localparam int CLR_TICKS   = 3;
   localparam int WAIT_W      = 8;
   localparam int LONG_TICKS  = 41;
`ifdef LCD_NIBBLE_MODE_EN
   localparam bit NIB = 1'b1;
`else
   localparam bit NIB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_in = 1'b1;
   logic       tick_in = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready, init_done, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   always #5 clk = ~clk;

   lcd_hd44780_writer #(
      .PWRUP_TICKS (PWRUP_TICKS),
      .CMD_TICKS   (CMD_TICKS),
      .CLR_TICKS   (CLR_TICKS),
      .WAIT_W      (WAIT_W)
   ) dut (
      .clkIn    (clk),
      .rstIn    (rst_in),
      .tickIn   (tick_in),
      .wrValid  (wr_valid),
      .wrReady  (wr_ready),
      .wrRs     (wr_rs),
      .wrData   (wr_data),
      .initDone (init_done),
      .lcdRs    (lcd_rs),
      .lcdRw    (lcd_rw),
      .lcdEn    (lcd_en),
      .lcdData  (lcd_data)
   );

   // One tick every 10 clocks, changed 1 ns after the edge.
   initial begin
      forever begin
         repeat (9) @(posedge clk);
         #1 tick_in = 1'b1;
         @(posedge clk);
         #1 tick_in = 1'b0;
      end
   end

   int tick_cnt = 0;
   always @(posedge clk) if (tick_in) tick_cnt <= tick_cnt + 1;

   // ---------------- reference model (driver side only) ----------------
   logic [8:0] exp_q[$];   // {rs, lcdData} per strobe
   int         lat_q[$];   // ticks from base to wrReady rising
   int         base_q[$];
   bit         stuck = 1'b0;
   bit         done_req = 1'b0;

   function automatic int wait_of(input logic rs, input logic [7:0] d);
      if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return CLR_TICKS;
      return CMD_TICKS;
   endfunction

   task automatic model_byte(input logic rs, input logic [7:0] d, input int w, output int ticks);
      if (NIB) begin
         exp_q.push_back({rs, d[7:4], 4'h0});
         exp_q.push_back({rs, d[3:0], 4'h0});
         ticks = 6 + w;
      end else begin
         exp_q.push_back({rs, d});
         ticks = 3 + w;
      end
   endtask

   task automatic model_nibble(input logic [3:0] n, input int w, output int ticks);
      exp_q.push_back({1'b0, n, 4'h0});
      ticks = 3 + w;
   endtask

   task automatic model_init(input int base);
      int total;
      int t;
      total = PWRUP_TICKS;
      if (NIB) begin
         model_nibble(4'h3, LONG_TICKS, t); total += t;
         model_nibble(4'h3, CMD_TICKS, t);  total += t;
         model_nibble(4'h3, CMD_TICKS, t);  total += t;
         model_nibble(4'h2, CMD_TICKS, t);  total += t;
         model_byte(1'b0, 8'h28, CMD_TICKS, t); total += t;
      end else begin
         model_byte(1'b0, 8'h30, LONG_TICKS, t); total += t;
         model_byte(1'b0, 8'h30, CMD_TICKS, t);  total += t;
         model_byte(1'b0, 8'h30, CMD_TICKS, t);  total += t;
         model_byte(1'b0, 8'h38, CMD_TICKS, t);  total += t;
      end
      model_byte(1'b0, 8'h0C, CMD_TICKS, t); total += t;
      model_byte(1'b0, 8'h01, CLR_TICKS, t); total += t;
      model_byte(1'b0, 8'h06, CMD_TICKS, t); total += t;
      lat_q.push_back(total);
      base_q.push_back(base);
   endtask

   // ---------------- driver ----------------
   task automatic do_reset();
      @(posedge clk);
      #1 rst_in = 1'b1;
      wr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_in = 1'b0;
      model_init(tick_cnt);
   endtask

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int n = 0; n < 3000 && !ok; n++) begin
         @(negedge clk);
         if (wr_ready) ok = 1'b1;
      end
      if (!ok) stuck = 1'b1;
   endtask

   // keep=1 leaves wrValid high with junk data afterwards; the DUT must
   // not take any of it until the next real byte is presented.
   task automatic do_write(input logic rs, input logic [7:0] d, input bit keep);
      bit got = 1'b0;
      int lat;
      int base;
      for (int n = 0; n < 3000 && !got; n++) begin
         @(negedge clk);
         if (wr_ready) begin
            wr_valid = 1'b1;
            wr_rs    = rs;
            wr_data  = d;
            @(posedge clk);
            #1;
            base = tick_cnt;
            model_byte(rs, d, wait_of(rs, d), lat);
            lat_q.push_back(lat);
            base_q.push_back(base);
            wr_valid = keep;
            wr_rs    = 1'($urandom_range(0, 1));
            wr_data  = 8'($urandom);
            got      = 1'b1;
         end else if (wr_valid) begin
            wr_rs   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
         end
      end
      if (!got) stuck = 1'b1;
   endtask

   initial begin
      bit seen;
      do_reset();
      wait_ready();
      do_write(1'b1, 8'h41, 1'b0);
      do_write(1'b0, 8'h01, 1'b0);
      do_write(1'b0, 8'h80, 1'b0);
      for (int i = 0; i < 5; i++)
         do_write(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      do_write(1'b1, 8'hA5, 1'b0);
      // Reset while the enable strobe is high.
      do_write(1'b1, 8'h55, 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(posedge clk);
         #1;
         if (lcd_en) seen = 1'b1;
      end
      if (!seen) stuck = 1'b1;
      do_reset();
      wait_ready();
      for (int i = 0; i < 4; i++)
         do_write(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      wait_ready();
      repeat (3) @(negedge clk);
      done_req = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   int         exp_rd = 0;
   int         lat_rd = 0;
   int         rise_tick = 0;
   int         rst_cnt = 0;
   int         cycles = 0;
   logic       en_prev = 1'b0;
   logic       rdy_prev = 1'b0;
   logic       hold_pend = 1'b0;
   logic [8:0] prev_bus = '0;
   logic [8:0] cur_bus = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [8:0] bus;
      forever begin
         @(negedge clk);
         bus = {lcd_rs, lcd_data};
         cycles++;
         if (done_req || cycles > 60000) begin
            chk("watchdog_expired", 32'(cycles > 60000), 0);
            chk("driver_stuck", 32'(stuck), 0);
            chk("strobes_outstanding", 32'(exp_q.size() - exp_rd), 0);
            chk("ready_outstanding", 32'(lat_q.size() - lat_rd), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end else if (rst_in) begin
            rst_cnt++;
            en_prev   = 1'b0;
            rdy_prev  = 1'b0;
            hold_pend = 1'b0;
            exp_rd    = exp_q.size();
            lat_rd    = lat_q.size();
            if (rst_cnt == 2) begin
               chk("rst_lcd_en", 32'(lcd_en), 0);
               chk("rst_init_done", 32'(init_done), 0);
               chk("rst_wr_ready", 32'(wr_ready), 0);
               chk("rst_lcd_bus", 32'(bus), 0);
               chk("rst_lcd_rw", 32'(lcd_rw), 0);
            end
         end else begin
            rst_cnt = 0;
            if (lcd_en && !en_prev) begin
               chk("strobe_expected", 32'(exp_q.size() > exp_rd), 1);
               if (exp_q.size() > exp_rd) begin
                  chk("strobe_bus", 32'(bus), 32'(exp_q[exp_rd]));
                  exp_rd++;
               end
               chk("setup_stable", 32'(bus), 32'(prev_bus));
               chk("rw_low", 32'(lcd_rw), 0);
               $display("strobe rs=%0b data=%02h tick=%0d", lcd_rs, lcd_data, tick_cnt);
               cur_bus   = bus;
               rise_tick = tick_cnt;
            end else if (!lcd_en && en_prev) begin
               chk("en_width_ticks", 32'(tick_cnt - rise_tick), 1);
               chk("fall_bus", 32'(bus), 32'(cur_bus));
               hold_pend = 1'b1;
            end else if (hold_pend && tick_in) begin
               chk("hold_bus", 32'(bus), 32'(cur_bus));
               hold_pend = 1'b0;
            end
            if (wr_ready && !rdy_prev) begin
               chk("ready_expected", 32'(lat_q.size() > lat_rd), 1);
               if (lat_q.size() > lat_rd) begin
                  chk("ready_latency", 32'(tick_cnt - base_q[lat_rd]), 32'(lat_q[lat_rd]));
                  chk("init_done_at_idle", 32'(init_done), 1);
                  $display("ready after %0d ticks", tick_cnt - base_q[lat_rd]);
                  lat_rd++;
               end
            end
            en_prev  = lcd_en;
            rdy_prev = wr_ready;
         end
         prev_bus = bus;
      end
   end

endmodule
